// File: rtl/ex_trap_req.sv
// External-interrupt initiator: synchronizes IRQ lines, latches rising edges as
// pending bits, and issues one fixed-priority valid/ready trap request at a time.

module ex_trap_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic set
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], irq};
      s_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign set = sync[SYNC_STAGES-1] & ~s_d;
endmodule

module ex_trap_req #(
  parameter int IRQ_NUM     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_CYC = 4,
  parameter int ID_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irq_i,
  input  logic [IRQ_NUM-1:0] irq_en_i,
  output logic               core_ex_trap_valid,
  input  logic               core_ex_trap_ready,
  output logic [ID_W-1:0]    trap_id_o,
  output logic [IRQ_NUM-1:0] pending_o,
  output logic               busy_o
);
  localparam int CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t             state, state_n;
  logic               valid_n;
  logic [ID_W-1:0]    id_n, win_id;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IRQ_NUM-1:0] set_vec, clr_vec, pending, elig;
  logic               accept;

  for (genvar g = 0; g < IRQ_NUM; g++) begin : g_lane
    ex_trap_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .irq  (irq_i[g]),
      .set  (set_vec[g])
    );
    assign clr_vec[g] = accept && (trap_id_o == ID_W'(g));
  end

  assign accept = (state == REQ) && core_ex_trap_ready;
  assign elig   = pending & irq_en_i;

  // Set is OR-ed in after the clear so a new edge on the accepted line survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_vec) | set_vec;
  end

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    win_id = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--)
      if (elig[i]) win_id = ID_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      core_ex_trap_valid <= 1'b0;
      trap_id_o          <= '0;
      cnt                <= '0;
    end else begin
      state              <= state_n;
      core_ex_trap_valid <= valid_n;
      trap_id_o          <= id_n;
      cnt                <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    valid_n = core_ex_trap_valid;
    id_n    = trap_id_o;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (|elig) begin
          id_n    = win_id;
          valid_n = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (core_ex_trap_ready) begin
          valid_n = 1'b0;
          cnt_n   = CNT_W'(HOLDOFF_CYC - 1);
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  assign pending_o = pending;
  assign busy_o    = (state != IDLE);
endmodule

// File: tb/tb_ex_trap_req.sv
// Directed bench for ex_trap_req: a queue of expected trap IDs is drained by a
// monitor on every accepted handshake; timing and state checks run inline.

module tb_ex_trap_req;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_i, irq_en_i;
  logic       core_ex_trap_valid, core_ex_trap_ready;
  logic [3:0] trap_id_o;
  logic [7:0] pending_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  ex_trap_req dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .irq_i             (irq_i),
    .irq_en_i          (irq_en_i),
    .core_ex_trap_valid(core_ex_trap_valid),
    .core_ex_trap_ready(core_ex_trap_ready),
    .trap_id_o         (trap_id_o),
    .pending_o         (pending_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!core_ex_trap_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk(name, {31'b0, core_ex_trap_valid}, 32'd1);
  endtask

  // Accept happens at the posedge following a negedge where valid&ready are high.
  always @(negedge clk) begin
    if (rst_n && core_ex_trap_valid && core_ex_trap_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got id %0d expected no request", trap_id_o);
      end else begin
        chk("sb_id", {28'b0, trap_id_o}, {28'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; irq_i = '0; irq_en_i = 8'hFF; core_ex_trap_ready = 1'b0;
    tick(2);
    chk("rst_valid", {31'b0, core_ex_trap_valid}, 32'd0);
    chk("rst_id",    {28'b0, trap_id_o}, 32'd0);
    chk("rst_pend",  {24'b0, pending_o}, 32'd0);
    chk("rst_busy",  {31'b0, busy_o}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single line, late accept
    irq_i[5] = 1'b1;
    tick(2);
    chk("t1_pend_early", {24'b0, pending_o}, 32'h00);
    tick(1);
    chk("t1_pend", {24'b0, pending_o}, 32'h20);
    chk("t1_novalid", {31'b0, core_ex_trap_valid}, 32'd0);
    tick(1);
    chk("t1_valid", {31'b0, core_ex_trap_valid}, 32'd1);
    chk("t1_id", {28'b0, trap_id_o}, 32'd5);
    exp_q.push_back(4'd5);
    irq_i[5] = 1'b0;
    tick(6);
    chk("t1_hold_valid", {31'b0, core_ex_trap_valid}, 32'd1);
    chk("t1_hold_id", {28'b0, trap_id_o}, 32'd5);
    core_ex_trap_ready = 1'b1;
    tick(1);
    core_ex_trap_ready = 1'b0;
    chk("t1_drop", {31'b0, core_ex_trap_valid}, 32'd0);
    chk("t1_clr", {24'b0, pending_o}, 32'h00);
    chk("t1_busy", {31'b0, busy_o}, 32'd1);
    tick(5);
    chk("t1_idle", {31'b0, busy_o}, 32'd0);

    // Priority and hold-off spacing
    core_ex_trap_ready = 1'b1;
    irq_i = 8'h44;
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd6);
    wait_valid("t2_valid1");
    chk("t2_id1", {28'b0, trap_id_o}, 32'd2);
    tick(1);
    chk("t2_drop1", {31'b0, core_ex_trap_valid}, 32'd0);
    chk("t2_pend", {24'b0, pending_o}, 32'h40);
    n = 0;
    do begin tick(1); n++; end while (!core_ex_trap_valid && n < 20);
    chk("t2_spacing", n, 32'd5);
    chk("t2_id2", {28'b0, trap_id_o}, 32'd6);
    tick(1);
    core_ex_trap_ready = 1'b0;
    irq_i = '0;
    chk("t2_clr", {24'b0, pending_o}, 32'h00);
    tick(5);

    // Mask
    irq_en_i = 8'h00;
    irq_i[3] = 1'b1;
    tick(1);
    irq_i[3] = 1'b0;
    tick(2);
    chk("t3_pend", {24'b0, pending_o}, 32'h08);
    tick(3);
    chk("t3_masked", {31'b0, core_ex_trap_valid}, 32'd0);
    irq_en_i = 8'h08;
    tick(1);
    chk("t3_valid", {31'b0, core_ex_trap_valid}, 32'd1);
    chk("t3_id", {28'b0, trap_id_o}, 32'd3);
    exp_q.push_back(4'd3);
    core_ex_trap_ready = 1'b1;
    tick(1);
    core_ex_trap_ready = 1'b0;
    chk("t3_clr", {24'b0, pending_o}, 32'h00);
    tick(5);
    irq_en_i = 8'hFF;

    // Freeze in REQ
    irq_i[4] = 1'b1;
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd0);
    wait_valid("t4_valid1");
    chk("t4_id1", {28'b0, trap_id_o}, 32'd4);
    irq_i[0] = 1'b1;
    tick(4);
    chk("t4_pend", {24'b0, pending_o}, 32'h11);
    chk("t4_frozen", {28'b0, trap_id_o}, 32'd4);
    core_ex_trap_ready = 1'b1;
    tick(1);
    core_ex_trap_ready = 1'b0;
    wait_valid("t4_valid2");
    chk("t4_id2", {28'b0, trap_id_o}, 32'd0);
    core_ex_trap_ready = 1'b1;
    tick(1);
    core_ex_trap_ready = 1'b0;
    irq_i = '0;
    tick(5);

    // Set/clear collision on line 1
    irq_i[1] = 1'b1;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd1);
    wait_valid("t5_valid1");
    irq_i[1] = 1'b0;
    tick(2);
    irq_i[1] = 1'b1;
    tick(2);
    core_ex_trap_ready = 1'b1;
    tick(1);
    core_ex_trap_ready = 1'b0;
    chk("t5_drop", {31'b0, core_ex_trap_valid}, 32'd0);
    chk("t5_pend_kept", {24'b0, pending_o}, 32'h02);
    n = 0;
    do begin tick(1); n++; end while (!core_ex_trap_valid && n < 20);
    chk("t5_spacing", n, 32'd5);
    chk("t5_id2", {28'b0, trap_id_o}, 32'd1);
    core_ex_trap_ready = 1'b1;
    tick(1);
    core_ex_trap_ready = 1'b0;
    irq_i = '0;
    chk("t5_clr", {24'b0, pending_o}, 32'h00);
    tick(5);

    // Async reset in REQ
    irq_i[7] = 1'b1;
    wait_valid("t6_valid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, core_ex_trap_valid}, 32'd0);
    chk("t6_async_pend",  {24'b0, pending_o}, 32'h00);
    chk("t6_async_busy",  {31'b0, busy_o}, 32'd0);
    irq_i = '0;
    tick(2);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (core_ex_trap_valid) n++;
    end
    chk("t6_no_req", n, 32'd0);
    chk("t6_pend_clean", {24'b0, pending_o}, 32'h00);
    irq_i[3] = 1'b1;
    exp_q.push_back(4'd3);
    wait_valid("t6_valid2");
    chk("t6_id2", {28'b0, trap_id_o}, 32'd3);
    core_ex_trap_ready = 1'b1;
    tick(1);
    core_ex_trap_ready = 1'b0;
    irq_i = '0;
    tick(2);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
